// File: rtl/key_scan_n_pkg.sv
// Shared constants and width helper for the multi-key debounce block.
package key_scan_pkg;

    localparam int DEB_CYCLES_DEF  = 1000000;
    localparam int LONG_CYCLES_DEF = 50000000;

    // key_value needs at least one bit even for a single channel.
    function automatic int key_value_width(input int n_keys);
        return (n_keys > 1) ? $clog2(n_keys) : 1;
    endfunction

endpackage

// File: rtl/key_scan_n_if.sv
// Key pins in, debounced levels and event pulses out; master is the debounce block.
interface key_scan_if #(
    parameter int N_KEYS = 2,
    parameter int VW     = 1
);
    logic [N_KEYS-1:0] key_in;
    logic [N_KEYS-1:0] key_state;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_long;
    logic              key_flag;
    logic [VW-1:0]     key_value;

    modport master (
        input  key_in,
        output key_state, key_press, key_release, key_long, key_flag, key_value
    );

    modport slave (
        output key_in,
        input  key_state, key_press, key_release, key_long, key_flag, key_value
    );
endinterface

// File: rtl/key_scan_n_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce counter, long-press counter.
module key_debounce_ch #(
    parameter int DEB_CYCLES  = 1000000,
    parameter int LONG_CYCLES = 50000000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic press_evt
);

    localparam int   DW      = $clog2(DEB_CYCLES);
    localparam int   LW      = $clog2(LONG_CYCLES + 1);
    localparam logic REL_LVL = (ACTIVE_LOW != 0);

    logic [1:0]    sync;
    logic          raw_s;
    logic          stable;
    logic [DW-1:0] deb_cnt;
    logic [LW-1:0] long_cnt;
    logic          deb_hit;
    logic          rel_evt;
    logic          long_evt;

    always_ff @(posedge clk) begin
        if (!rst_n) sync <= {2{REL_LVL}};
        else        sync <= {sync[0], key_in};
    end

    assign raw_s    = sync[1] ^ REL_LVL;
    assign deb_hit  = (raw_s != stable) && (deb_cnt == DW'(DEB_CYCLES - 1));
    assign press_evt = deb_hit & raw_s;
    assign rel_evt   = deb_hit & ~raw_s;
    // A release landing on the final count still suppresses key_long.
    assign long_evt  = stable && !rel_evt && (long_cnt == LW'(LONG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable  <= 1'b0;
            deb_cnt <= '0;
        end else if (raw_s == stable) begin
            deb_cnt <= '0;
        end else if (deb_hit) begin
            stable  <= raw_s;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !stable || rel_evt) long_cnt <= '0;
        else if (long_cnt != LW'(LONG_CYCLES)) long_cnt <= long_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            key_press   <= press_evt;
            key_release <= rel_evt;
            key_long    <= long_evt;
        end
    end

    assign key_state = stable;

endmodule

// File: rtl/key_scan_n.sv
// N-channel key debounce with aggregate flag and lowest-index press encoder.
module key_scan_n
    import key_scan_pkg::*;
#(
    parameter int N_KEYS      = 2,
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int LONG_CYCLES = LONG_CYCLES_DEF,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    key_scan_if.master   keys
);

    localparam int VW = key_value_width(N_KEYS);

    logic [N_KEYS-1:0] state_v;
    logic [N_KEYS-1:0] press_v;
    logic [N_KEYS-1:0] release_v;
    logic [N_KEYS-1:0] long_v;
    logic [N_KEYS-1:0] press_nxt;
    logic              any_press;
    logic [VW-1:0]     first_idx;
    logic              flag_q;
    logic [VW-1:0]     value_q;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEB_CYCLES (DEB_CYCLES),
            .LONG_CYCLES(LONG_CYCLES),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .key_in     (keys.key_in[i]),
            .key_state  (state_v[i]),
            .key_press  (press_v[i]),
            .key_release(release_v[i]),
            .key_long   (long_v[i]),
            .press_evt  (press_nxt[i])
        );
    end

    // Encoder works on the pre-register press events so flag/value line up with key_press.
    always_comb begin
        any_press = |press_nxt;
        first_idx = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (press_nxt[i]) first_idx = VW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_q  <= 1'b0;
            value_q <= '0;
        end else begin
            flag_q <= any_press;
            if (any_press) value_q <= first_idx;
        end
    end

    assign keys.key_state   = state_v;
    assign keys.key_press   = press_v;
    assign keys.key_release = release_v;
    assign keys.key_long    = long_v;
    assign keys.key_flag    = flag_q;
    assign keys.key_value   = value_q;

endmodule

// File: tb/tb_key_scan_n.sv
// Randomised and directed bench for key_scan_n against a window-based reference model.
module tb_key_scan_n;
    import key_scan_pkg::*;

    localparam int N    = 4;
    localparam int DEB  = 8;
    localparam int LONG = 32;
    localparam int VW   = key_value_width(N);
    localparam int OW   = 4 * N + 1 + VW;
    localparam logic [DEB-1:0] ONES = '1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    key_scan_if #(.N_KEYS(N), .VW(VW)) keys ();

    key_scan_n #(
        .N_KEYS(N), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .ACTIVE_LOW(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .keys (keys)
    );

    wire [OW-1:0] dut_vec = {keys.key_state, keys.key_press, keys.key_release,
                             keys.key_long, keys.key_flag, keys.key_value};

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: pressed-ness seen two edges late, a level is accepted once the
    // last DEB samples all disagree with it; long fires LONG edges after the press.
    logic [N-1:0]   m_s1, m_s2, m_stable;
    logic [DEB-1:0] m_win [N];
    int             m_nv [N];
    longint         m_press_t [N];
    longint         cyc = 0;
    logic [N-1:0]   e_press, e_rel, e_long;
    logic           e_flag;
    logic [VW-1:0]  e_value;
    logic [OW-1:0]  exp_vec = '0;
    logic [VW-1:0]  exp_q [$];
    logic [VW-1:0]  got_q [$];

    task automatic model_step();
        logic [N-1:0] r;
        cyc++;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0;
            e_press = '0; e_rel = '0; e_long = '0; e_flag = 1'b0; e_value = '0;
            for (int i = 0; i < N; i++) begin
                m_win[i] = '0; m_nv[i] = 0; m_press_t[i] = -1;
            end
        end else begin
            r = m_s2; m_s2 = m_s1; m_s1 = ~keys.key_in;
            e_press = '0; e_rel = '0; e_long = '0;
            for (int i = 0; i < N; i++) begin
                m_win[i] = {m_win[i][DEB-2:0], r[i]};
                if (m_nv[i] < DEB) m_nv[i]++;
                if (m_nv[i] == DEB && m_win[i] == (m_stable[i] ? '0 : ONES)) begin
                    if (m_stable[i]) begin e_rel[i] = 1'b1; m_press_t[i] = -1; end
                    else begin e_press[i] = 1'b1; m_press_t[i] = cyc; end
                    m_stable[i] = ~m_stable[i];
                end else if (m_stable[i] && m_press_t[i] >= 0 && cyc == m_press_t[i] + LONG) begin
                    e_long[i] = 1'b1;
                end
            end
            e_flag = |e_press;
            if (e_flag) begin
                for (int j = 0; j < N; j++) begin
                    if (e_press[j]) begin e_value = VW'(j); break; end
                end
                exp_q.push_back(e_value);
            end
        end
        exp_vec = {m_stable, e_press, e_rel, e_long, e_flag, e_value};
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (keys.key_flag === 1'b1) got_q.push_back(keys.key_value);
    endtask

    task automatic test_reset();
        keys.key_in = '1;
        rst_n = 1'b0;
        repeat (3) begin
            tick();
            n_cmp++;
            if (dut_vec !== '0) begin
                n_fail++; $display("FAIL reset_zero: got %h want 0", dut_vec);
            end
        end
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_fail++; $display("FAIL reset_idle: got %h want %h", dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_single_press();
        keys.key_in[1] = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_fail++; $display("FAIL single_model c=%0d: got %h want %h", c, dut_vec, exp_vec);
            end
            if (c == 9 || c == 10 || c == 11) begin
                n_cmp++;
                if (keys.key_state[1] !== (c >= 10) || keys.key_press !== ((c == 10) ? 4'b0010 : 4'b0000) ||
                    keys.key_flag !== (c == 10) || (c >= 10 && keys.key_value !== 2'd1)) begin
                    n_fail++;
                    $display("FAIL single_press c=%0d: state=%b press=%b flag=%b value=%0d want press at c=10 value=1",
                             c, keys.key_state, keys.key_press, keys.key_flag, keys.key_value);
                end
            end
        end
        keys.key_in[1] = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec || keys.key_release[1] !== (c == 10)) begin
                n_fail++; $display("FAIL single_release c=%0d: got %h want %h", c, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_glitch();
        repeat (5) begin
            for (int h = 0; h < 2; h++) begin
                keys.key_in[0] = (h == 1);
                repeat (7) begin
                    tick();
                    n_cmp++;
                    if (dut_vec !== exp_vec || keys.key_press !== '0 || keys.key_flag !== 1'b0 ||
                        keys.key_state !== '0) begin
                        n_fail++; $display("FAIL glitch: got %h want %h, no event", dut_vec, exp_vec);
                    end
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        keys.key_in[3:2] = 2'b00;
        for (int c = 1; c <= 11; c++) begin
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_fail++; $display("FAIL simul_model c=%0d: got %h want %h", c, dut_vec, exp_vec);
            end
            if (c >= 10) begin
                n_cmp++;
                if (keys.key_press !== ((c == 10) ? 4'b1100 : 4'b0000) || keys.key_flag !== (c == 10) ||
                    keys.key_value !== 2'd2) begin
                    n_fail++;
                    $display("FAIL simul_press c=%0d: press=%b flag=%b value=%0d want 1100/1/2 at c=10",
                             c, keys.key_press, keys.key_flag, keys.key_value);
                end
            end
        end
        keys.key_in[3:2] = 2'b11;
        repeat (12) begin
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_fail++; $display("FAIL simul_release: got %h want %h", dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_long_press();
        int n_long;
        n_long = 0;
        keys.key_in[0] = 1'b0;
        repeat (10) tick();
        n_cmp++;
        if (keys.key_press[0] !== 1'b1 || dut_vec !== exp_vec) begin
            n_fail++; $display("FAIL long_setup: press0=%b got %h want %h", keys.key_press[0], dut_vec, exp_vec);
        end
        for (int k = 1; k <= 50; k++) begin
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec || keys.key_long[0] !== (k == LONG)) begin
                n_fail++; $display("FAIL long_pulse k=%0d: long=%b want %b", k, keys.key_long[0], (k == LONG));
            end
            if (keys.key_long[0] === 1'b1) n_long++;
        end
        n_cmp++;
        if (n_long != 1) begin
            n_fail++; $display("FAIL long_once: got %0d pulses want 1", n_long);
        end
        keys.key_in[0] = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec || keys.key_release[0] !== (c == 10) || keys.key_long !== '0) begin
                n_fail++; $display("FAIL long_release c=%0d: rel=%b long=%b want rel at c=10, no long",
                                   c, keys.key_release, keys.key_long);
            end
        end
    endtask

    task automatic test_reset_mid();
        keys.key_in[3] = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        repeat (3) begin
            tick();
            n_cmp++;
            if (dut_vec !== '0) begin
                n_fail++; $display("FAIL midreset_zero: got %h want 0", dut_vec);
            end
        end
        rst_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec || keys.key_press[3] !== (c == 10) ||
                (c == 10 && (keys.key_value !== 2'd3 || keys.key_flag !== 1'b1))) begin
                n_fail++; $display("FAIL midreset_press c=%0d: press=%b value=%0d want press3 at c=10 value=3",
                                   c, keys.key_press, keys.key_value);
            end
        end
        keys.key_in[3] = 1'b1;
        repeat (12) begin
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_fail++; $display("FAIL midreset_release: got %h want %h", dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        int hold [N];
        int rst_left;
        rst_left = 0;
        for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 14);
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    keys.key_in[i] = ~keys.key_in[i];
                    hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 60) : $urandom_range(1, 14);
                end
            end
            if (rst_left > 0) rst_left--;
            else if ($urandom_range(0, 299) == 0) rst_left = $urandom_range(1, 3);
            rst_n = (rst_left == 0);
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_fail++; $display("FAIL random c=%0d: got %h want %h", c, dut_vec, exp_vec);
            end
        end
        rst_n = 1'b1;
        keys.key_in = '1;
        repeat (12) begin
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_fail++; $display("FAIL random_drain: got %h want %h", dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_scoreboard();
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL sb_count: got %0d presses want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [VW-1:0] g, e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_fail++; $display("FAIL sb_value: got %0d want %0d", g, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_simultaneous();
        test_long_press();
        test_reset_mid();
        test_random();
        test_scoreboard();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/key_scan_n.md
# key_scan_n

Parametrised multi-key debounce and event block: N independent key inputs are synchronised, debounced, and turned into clean levels plus one-cycle press, release and long-press pulses. An aggregate key_flag/key_value pair reports the index of each newly pressed key. It sits between the board pushbuttons and the control logic.

## Interface

Parameters:
- N_KEYS, 2, number of key channels, at least 1.
- DEB_CYCLES, 1000000, number of stable cycles required to accept a level change, at least 2.
- LONG_CYCLES, 50000000, number of cycles a key must stay pressed before key_long fires, at least 1.
- ACTIVE_LOW, 1. When 1, key_in low means pressed. When 0, key_in high means pressed.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, reset: synchronous, active-low.
- key_in, input, N_KEYS, raw asynchronous key pins.
- key_state, output, N_KEYS, debounced level (1 = pressed).
- key_press, output, N_KEYS, one-cycle pulse per channel on accepted press.
- key_release, output, N_KEYS, one-cycle pulse per channel on accepted release.
- key_long, output, N_KEYS, one-cycle pulse when a press has been held for LONG_CYCLES.
- key_flag, output, 1, one-cycle pulse when any key_press bit is set.
- key_value, output, VW, where VW = max(1, clog2(N_KEYS)). Holds the index of the last reported press.

## Operation

Per channel:
- Synchronise key_in through a 2-flop synchroniser.
- Normalise polarity to raw_s, where 1 = pressed.
- The synchroniser flops reset to the released level.
- The debounced register stable resets to 0 (released).

Debounce counter (width clog2(DEB_CYCLES)):
- If raw_s equals stable, deb_cnt is cleared to 0.
- Otherwise, if deb_cnt equals DEB_CYCLES-1: stable takes the value of raw_s and deb_cnt clears to 0. In the same cycle, key_press (for a 0 to 1 change) or key_release (for a 1 to 0 change) is asserted.
- Otherwise deb_cnt increments.
- A glitch shorter than DEB_CYCLES produces no event, and the count restarts from 0.

Long-press counter (width clog2(LONG_CYCLES+1)):
- Clears while stable is 0.
- While stable is 1, it counts up and saturates at LONG_CYCLES.
- key_long pulses in the cycle the counter reaches LONG_CYCLES. The pulse is emitted once per press and does not auto-repeat.
- A release clears the counter. The next press can fire key_long again.

Aggregate outputs:
- key_flag is the OR of all key_press bits.
- key_value loads the lowest index i with key_press[i] set. It loads only in cycles where key_flag is asserted, and otherwise holds.
- Simultaneous presses: all bits are visible on key_press, and key_value reports the lowest index.

Reset:
- All outputs are 0 while rst_n is low, and all counters are cleared.
- A key held through reset is reported as a fresh press after reset is released.

## Timing

- All outputs are registered and change only on the rising edge of clk.
- A clean edge on key_in appears on key_state exactly 2 + DEB_CYCLES cycles later. key_press or key_release is asserted in that same cycle.
- key_long is asserted exactly LONG_CYCLES cycles after the key_press pulse, provided there is no release in between.
- key_flag and key_value update in the same cycle as key_press. There is no extra latency.
- Every pulse output is exactly 1 cycle wide.
- Channels are fully independent, with no arbitration stalls.

## Structure

- Package key_scan_pkg contains:
  - the default constants DEB_CYCLES_DEF and LONG_CYCLES_DEF;
  - a helper function for the key_value width.
- Sub-module key_debounce_ch covers one channel: the synchroniser, polarity normalisation, debounce counter, long-press counter, and the state, press, release and long outputs.
- The top level instantiates key_debounce_ch with a generate loop over N_KEYS. It also contains the OR reduction and the lowest-index priority encoder for key_flag and key_value.

## Test plan

All scenarios use N_KEYS=4, DEB_CYCLES=8, LONG_CYCLES=32, ACTIVE_LOW=1.

- Hold key_in[1] low from cycle 0 -> at cycle 10, key_state[1] rises, key_press[1], key_flag and key_value are updated, with key_value=1 and the pulses 1 cycle wide.
- Drive key_in[0] low for 7 cycles, then high, repeated 5 times -> no key_press, key_flag or key_state change.
- Press keys 2 and 3 low in the same cycle -> key_press=4'b1100, key_flag=1 for one cycle, key_value=2.
- Hold key 0 for 50 cycles after key_press[0] -> key_long[0] pulses once, 32 cycles after key_press. Then release -> key_release[0] 10 cycles after the release edge, and key_long does not repeat.
- Hold key 3 low, and assert rst_n=0 for 3 cycles mid-count -> all outputs read 0 during reset. key_press[3] arrives 10 cycles after rst_n returns high, with key_value=3.
